video_sync_rx: RTL and testbench
================================

// Module: video_sync_rx
// PURPOSE
//  Sink end of the video_if link: takes HS/VS/BLANK/RGB from a timing generator or external source.
//  Recovers pixel coordinates, measures line/frame totals and checks the active size against HDISP x VDISP.
//  Declares lock only after consistent frames; downstream capture/processing consumes pix_* when locked.
// PARAMETERS
//  HDISP        800  active pixels per line
//  VDISP        480  active lines per frame
//  LOCK_FRAMES  2    consecutive good frames needed to enter LOCKED (>=1)
// PORTS
//  pixel_clk    in   1              pixel clock
//  pixel_rst    in   1              reset
//  vid_hs       in   1              horizontal sync, active low
//  vid_vs       in   1              vertical sync, active low
//  vid_blank    in   1              1 = active (displayed) pixel, 0 = blanking
//  vid_rgb      in   24             pixel data {R,G,B}, meaningful when vid_blank=1
//  pix_valid    out  1              pix_x/pix_y/pix_rgb valid (active pixel while LOCKED)
//  pix_x        out  $clog2(HDISP)  column of current pixel
//  pix_y        out  $clog2(VDISP)  line of current pixel
//  pix_rgb      out  24             registered pixel data
//  pix_sof      out  1              with pix_valid: pixel (0,0)
//  pix_eol      out  1              with pix_valid: pix_x == HDISP-1
//  locked       out  1              1 while state == LOCKED
//  err_size     out  1              1-cycle pulse: line or frame size mismatch detected
//  meas_htotal  out  12             clocks between the last two HS falling edges, saturates at 4095
//  meas_vtotal  out  12             HS falling edges between the last two VS falling edges, saturates at 4095
// BEHAVIOUR
//  Reset: pixel_rst, asynchronous, active-high; clock pixel_clk. All outputs 0 and state SEARCH during and after reset.
//  Input stage: all vid_* registered once (hs_r, vs_r, de_r, rgb_r); edges come from hs_r/vs_r vs a second delay register.
//  pix_* outputs are registered: pix_valid follows vid_blank by exactly 2 clocks (input reg + output reg).
//  Horizontal: x increments each cycle with de_r=1; clears on de_r falling edge.
//   - x reaching HDISP with de_r still 1 = overrun: x holds HDISP-1, line is marked bad.
//  Line end (de_r falling edge): line is good iff exactly HDISP active cycles; y += 1, saturating at VDISP.
//  Frame end (vs_r falling edge): frame good iff exactly VDISP lines, all good, no overrun.
//   - y clears to 0 and line/frame flags are reinitialised in the same cycle.
//   - meas_vtotal updates in the same cycle (count of HS falling edges seen since previous VS falling edge).
//  meas_htotal updates on each hs_r falling edge; the cycle counter restarts at 1 in that cycle.
//  Both meas_* hold 0 until two edges of their reference sync have been seen since reset.
//  FSM (state updates on vs_r falling edge only):
//   - SEARCH -> CHECK on the first VS falling edge (the frame just ended is partial, not judged).
//   - CHECK: good frame -> good_cnt++; good_cnt == LOCK_FRAMES -> LOCKED; bad frame -> good_cnt=0, stay CHECK.
//   - LOCKED: bad frame -> SEARCH with err_size pulse; locked drops the cycle after the VS falling edge.
//  err_size also pulses in CHECK/LOCKED on any bad line, in the cycle after the de_r falling edge; it pulses once per event.
//  pix_valid = de_r && state == LOCKED. LOCKED is entered at a VS edge, so output always starts at pix_sof.
//  Mid-frame error while LOCKED: pixel output keeps flowing to frame end; the frame is judged at VS.
//  Overrun pixels are dropped: pix_valid=0 beyond HDISP.
//  Simultaneous de_r fall and vs_r fall: line end is processed first, then the frame check.
//  Reset mid-frame: counters/state cleared immediately; relock needs 1 partial + LOCK_FRAMES full frames.
// TESTING
//  1. Gen 800x480, HFP40/HPULSE48/HBP40, VFP12/VPULSE3/VBP40, reset at t0:
//     meas_htotal=928, meas_vtotal=535; locked rises after the 3rd VS fall; no err_size.
//  2. Locked stream, pixel data = {x[7:0],y[7:0],8'hA5}:
//     pix_rgb/pix_x/pix_y match, pix_valid lags vid_blank by 2 clocks.
//     Exactly 384000 pix_valid per frame; one pix_sof and 480 pix_eol per frame.
//  3. While locked, one line with 801 active pixels: err_size pulse after that line.
//     Pixel 801 not output; at next VS locked=0; relock after LOCK_FRAMES good frames.
//  4. While locked, frame with 479 lines: err_size at VS, state SEARCH, meas_vtotal=534.
//  5. Assert pixel_rst for 3 clocks mid-line while locked: all outputs 0 asynchronously.
//     After release locked rises at the 3rd VS fall and meas_* are 0 until two syncs are seen.
//  6. CHECK state alternating good/bad frames: locked never asserts (good_cnt resets), err_size once per bad frame.

Source files
------------

// File: rtl/video_sync_rx_if.sv
// Raw video link from a timing generator into a sync receiver.
// Pure stream, no backpressure: the source drives every cycle and vid_blank=1 qualifies vid_rgb.
interface video_sync_rx_if;
    logic        vid_hs;
    logic        vid_vs;
    logic        vid_blank;
    logic [23:0] vid_rgb;

    modport master (output vid_hs, output vid_vs, output vid_blank, output vid_rgb);
    modport slave  (input  vid_hs, input  vid_vs, input  vid_blank, input  vid_rgb);
endinterface

// File: rtl/video_sync_rx.sv
// Video sync receiver: recovers pixel coordinates, measures line/frame totals and
// locks onto a stream whose active area matches HDISP x VDISP.
module video_sync_rx #(
    parameter int HDISP       = 800,
    parameter int VDISP       = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic                       pixel_clk,
    input  logic                       pixel_rst,
    video_sync_rx_if.slave             vid,
    output logic                       pix_valid,
    output logic [$clog2(HDISP)-1:0]   pix_x,
    output logic [$clog2(VDISP)-1:0]   pix_y,
    output logic [23:0]                pix_rgb,
    output logic                       pix_sof,
    output logic                       pix_eol,
    output logic                       locked,
    output logic                       err_size,
    output logic [11:0]                meas_htotal,
    output logic [11:0]                meas_vtotal,
    output logic [1:0]                 dbg_state
);
    localparam int XW  = $clog2(HDISP);
    localparam int YW  = $clog2(VDISP);
    localparam int YCW = $clog2(VDISP + 1);
    localparam int GW  = $clog2(LOCK_FRAMES + 1);

    typedef enum logic [1:0] {SEARCH = 2'd0, CHECK = 2'd1, LOCKED = 2'd2} state_t;

    state_t          state, state_nxt;
    logic [GW-1:0]   good_cnt, good_cnt_nxt;
    logic            hs_r, vs_r, de_r, hs_d, vs_d, de_d;
    logic [23:0]     rgb_r;
    logic            hs_fall, vs_fall, de_fall;
    logic [XW-1:0]   x_cnt;
    logic            line_full, line_ovr, line_good;
    logic [YCW-1:0]  y_cnt, y_after;
    logic            frame_bad, frame_bad_after, frame_good;
    logic [11:0]     h_cnt, v_cnt;
    logic            hs_seen, vs_seen;
    logic            err_nxt, valid_nxt;

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            hs_r  <= 1'b0;
            vs_r  <= 1'b0;
            de_r  <= 1'b0;
            rgb_r <= '0;
            hs_d  <= 1'b0;
            vs_d  <= 1'b0;
            de_d  <= 1'b0;
        end else begin
            hs_r  <= vid.vid_hs;
            vs_r  <= vid.vid_vs;
            de_r  <= vid.vid_blank;
            rgb_r <= vid.vid_rgb;
            hs_d  <= hs_r;
            vs_d  <= vs_r;
            de_d  <= de_r;
        end
    end

    assign hs_fall = hs_d & ~hs_r;
    assign vs_fall = vs_d & ~vs_r;
    assign de_fall = de_d & ~de_r;

    // line_full marks that column HDISP-1 was seen; any further active cycle is an overrun.
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            x_cnt     <= '0;
            line_full <= 1'b0;
            line_ovr  <= 1'b0;
        end else if (!de_r) begin
            x_cnt     <= '0;
            line_full <= 1'b0;
            line_ovr  <= 1'b0;
        end else if (line_full) begin
            line_ovr  <= 1'b1;
        end else if (x_cnt == XW'(HDISP - 1)) begin
            line_full <= 1'b1;
        end else begin
            x_cnt     <= x_cnt + XW'(1);
        end
    end

    // Line end is folded in before the frame verdict so a coincident DE/VS fall judges the full frame.
    always_comb begin
        line_good       = line_full & ~line_ovr;
        y_after         = y_cnt;
        frame_bad_after = frame_bad;
        if (de_fall) begin
            if (y_cnt != YCW'(VDISP)) y_after = y_cnt + YCW'(1);
            else                      frame_bad_after = 1'b1;
            if (!line_good)           frame_bad_after = 1'b1;
        end
        frame_good = (y_after == YCW'(VDISP)) && !frame_bad_after;
    end

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            y_cnt     <= '0;
            frame_bad <= 1'b0;
        end else if (vs_fall) begin
            y_cnt     <= '0;
            frame_bad <= 1'b0;
        end else begin
            y_cnt     <= y_after;
            frame_bad <= frame_bad_after;
        end
    end

    // A coincident HS fall belongs to the frame that is closing.
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            hs_seen     <= 1'b0;
            vs_seen     <= 1'b0;
            meas_htotal <= '0;
            meas_vtotal <= '0;
        end else begin
            if (hs_fall) begin
                h_cnt   <= 12'd1;
                hs_seen <= 1'b1;
                if (hs_seen) meas_htotal <= h_cnt;
            end else if (h_cnt != 12'hFFF) begin
                h_cnt <= h_cnt + 12'd1;
            end
            if (vs_fall) begin
                v_cnt   <= '0;
                vs_seen <= 1'b1;
                if (vs_seen)
                    meas_vtotal <= (hs_fall && v_cnt != 12'hFFF) ? v_cnt + 12'd1 : v_cnt;
            end else if (hs_fall && v_cnt != 12'hFFF) begin
                v_cnt <= v_cnt + 12'd1;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        good_cnt_nxt = good_cnt;
        if (vs_fall) begin
            case (state)
                SEARCH: begin
                    state_nxt    = CHECK;
                    good_cnt_nxt = '0;
                end
                CHECK: begin
                    if (!frame_good) begin
                        good_cnt_nxt = '0;
                    end else if (good_cnt == GW'(LOCK_FRAMES - 1)) begin
                        state_nxt    = LOCKED;
                        good_cnt_nxt = '0;
                    end else begin
                        good_cnt_nxt = good_cnt + GW'(1);
                    end
                end
                LOCKED: if (!frame_good) state_nxt = SEARCH;
                default: state_nxt = SEARCH;
            endcase
        end
        err_nxt   = ((state != SEARCH) && de_fall && !line_good) ||
                    ((state == LOCKED) && vs_fall && !frame_good);
        valid_nxt = de_r && (state == LOCKED) && !line_full;
    end

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            state    <= SEARCH;
            good_cnt <= '0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_cnt_nxt;
        end
    end

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_rgb   <= '0;
            pix_sof   <= 1'b0;
            pix_eol   <= 1'b0;
            err_size  <= 1'b0;
        end else begin
            pix_valid <= valid_nxt;
            pix_x     <= x_cnt;
            pix_y     <= y_cnt[YW-1:0];
            pix_rgb   <= rgb_r;
            pix_sof   <= valid_nxt && (x_cnt == '0) && (y_cnt == '0);
            pix_eol   <= valid_nxt && (x_cnt == XW'(HDISP - 1));
            err_size  <= err_nxt;
        end
    end

    assign locked    = (state == LOCKED);
    assign dbg_state = state;
endmodule

// File: tb/tb_video_sync_rx.sv
// Directed bench for video_sync_rx on a reduced 16x8 raster: a table of frame recipes
// with hand-computed outcomes, a pixel scoreboard, and a mid-frame reset sequence.
module tb_video_sync_rx;
    localparam int HDISP = 16, VDISP = 8, LOCK_FRAMES = 2;
    localparam int HPULSE = 4, HBP = 3, HFP = 3;
    localparam int VPULSE = 2, VBP = 2, VFP = 2;
    localparam int LINE_TOT = HPULSE + HBP + HDISP + HFP;
    localparam int NF = 22;

    logic        pixel_clk = 1'b0;
    logic        pixel_rst = 1'b0;
    logic        pix_valid, pix_sof, pix_eol, locked, err_size;
    logic [$clog2(HDISP)-1:0] pix_x;
    logic [$clog2(VDISP)-1:0] pix_y;
    logic [23:0] pix_rgb;
    logic [11:0] meas_htotal, meas_vtotal;
    logic [1:0]  dbg_state;

    video_sync_rx_if vid();

    video_sync_rx #(.HDISP(HDISP), .VDISP(VDISP), .LOCK_FRAMES(LOCK_FRAMES)) dut (
        .pixel_clk   (pixel_clk),
        .pixel_rst   (pixel_rst),
        .vid         (vid),
        .pix_valid   (pix_valid),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_rgb     (pix_rgb),
        .pix_sof     (pix_sof),
        .pix_eol     (pix_eol),
        .locked      (locked),
        .err_size    (err_size),
        .meas_htotal (meas_htotal),
        .meas_vtotal (meas_vtotal),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    always #5 pixel_clk = ~pixel_clk;

    int cyc = 0;
    always @(posedge pixel_clk) cyc <= cyc + 1;

    initial begin
        #2ms;
        $display("FAIL watchdog: run did not end, cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // scoreboard
    typedef struct packed {
        int          due;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [23:0] rgb;
        logic        sof;
        logic        eol;
    } pix_exp_t;
    localparam int EW = $bits(pix_exp_t);
    logic [EW-1:0] exp_q[$];

    int n_valid, n_sof, n_eol, n_err;
    pix_exp_t mon_e;
    bit       mon_pend;

    always @(negedge pixel_clk) begin
        if (pixel_rst) begin
            check("reset_outputs", {pix_valid, pix_x, pix_y, pix_rgb, pix_sof, pix_eol,
                                    locked, err_size, meas_htotal, meas_vtotal, dbg_state}, 64'd0);
        end else begin
            mon_pend = 1'b1;
            while (mon_pend) begin
                mon_pend = 1'b0;
                if (exp_q.size() > 0) begin
                    mon_e = exp_q[0];
                    if (mon_e.due < cyc) begin
                        total++;
                        bad++;
                        $display("FAIL pix_missing: x=%0d y=%0d due cycle %0d not seen by %0d",
                                 mon_e.x, mon_e.y, mon_e.due, cyc);
                        void'(exp_q.pop_front());
                        mon_pend = 1'b1;
                    end
                end
            end
            if (pix_valid) begin
                n_valid++;
                if (pix_sof) n_sof++;
                if (pix_eol) n_eol++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pix_unexpected: x=%0d y=%0d, required no pixel", pix_x, pix_y);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pix_latency", cyc, mon_e.due);
                    check("pix_x", pix_x, mon_e.x);
                    check("pix_y", pix_y, mon_e.y);
                    check("pix_rgb", pix_rgb, mon_e.rgb);
                    check("pix_sof", pix_sof, mon_e.sof);
                    check("pix_eol", pix_eol, mon_e.eol);
                end
            end else begin
                check("pix_flags_idle", {pix_sof, pix_eol}, 64'd0);
            end
            if (err_size) n_err++;
        end
    end

    // driver
    logic exp_lock  = 1'b0;
    int   rst_lines = -1;

    task automatic drive_cycle(input logic hs, input logic vs, input logic blank, input int x, input int y);
        pix_exp_t e;
        vid.vid_hs    = hs;
        vid.vid_vs    = vs;
        vid.vid_blank = blank;
        vid.vid_rgb   = blank ? {x[7:0], y[7:0], 8'hA5} : 24'h0;
        if (blank && exp_lock && x < HDISP && !pixel_rst) begin
            e.due = cyc + 2;
            e.x   = x[7:0];
            e.y   = y[7:0];
            e.rgb = {x[7:0], y[7:0], 8'hA5};
            e.sof = (x == 0 && y == 0);
            e.eol = (x == HDISP - 1);
            exp_q.push_back(e);
        end
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic drive_line(input logic vs, input int len, input int y, input int rst_at);
        int pad;
        if (rst_lines >= 0) rst_lines++;
        for (int i = 0; i < HPULSE; i++) drive_cycle(1'b0, vs, 1'b0, 0, y);
        for (int i = 0; i < HBP; i++)    drive_cycle(1'b1, vs, 1'b0, 0, y);
        for (int x = 0; x < len; x++) begin
            if (rst_at >= 0 && x == rst_at) begin
                pixel_rst = 1'b1;
                exp_lock  = 1'b0;
                exp_q.delete();
                #1;
                check("async_reset_outputs", {pix_valid, pix_x, pix_y, pix_rgb, pix_sof, pix_eol,
                                              locked, err_size, meas_htotal, meas_vtotal}, 64'd0);
            end
            if (rst_at >= 0 && x == rst_at + 3) begin
                pixel_rst = 1'b0;
                rst_lines = 0;
                check("meas_after_release", {meas_htotal, meas_vtotal}, 64'd0);
            end
            drive_cycle(1'b1, vs, 1'b1, x, y);
        end
        pad = HFP + ((len < HDISP) ? HDISP - len : 0);
        for (int i = 0; i < pad; i++) drive_cycle(1'b1, vs, 1'b0, 0, y);
        if (rst_lines == 1) check("meas_htotal_one_hs", meas_htotal, 64'd0);
        if (rst_lines == 2) begin
            check("meas_htotal_two_hs", meas_htotal, LINE_TOT);
            rst_lines = -1;
        end
    endtask

    typedef struct {
        int n_lines;
        int bad_line;
        int bad_len;
        int rst_line;
        bit exp_lock;
        int exp_err;
        int exp_vtot;
    } frame_rec_t;

    frame_rec_t tbl[NF];

    function automatic frame_rec_t rec(input int n, input int bl, input int blen, input int rl,
                                       input bit lk, input int er, input int vt);
        frame_rec_t r;
        r.n_lines = n;  r.bad_line = bl; r.bad_len  = blen; r.rst_line = rl;
        r.exp_lock = lk; r.exp_err = er; r.exp_vtot = vt;
        return r;
    endfunction

    task automatic drive_frame(input int f, input frame_rec_t r);
        int   nl, a, len, ev, eo;
        logic vs;
        nl = VPULSE + VBP + r.n_lines + VFP;
        n_valid = 0; n_sof = 0; n_eol = 0; n_err = 0;
        exp_lock = r.exp_lock;
        for (int l = 0; l < nl; l++) begin
            a   = l - (VPULSE + VBP);
            vs  = (l < VPULSE) ? 1'b0 : 1'b1;
            len = (a >= 0 && a < r.n_lines) ? ((a == r.bad_line) ? r.bad_len : HDISP) : 0;
            drive_line(vs, len, (a < 0) ? 0 : a, (a == r.rst_line) ? 5 : -1);
        end
        check($sformatf("f%0d_locked", f), locked, exp_lock);
        check($sformatf("f%0d_err_pulses", f), n_err, r.exp_err);
        check($sformatf("f%0d_meas_vtotal", f), meas_vtotal, r.exp_vtot);
        check($sformatf("f%0d_meas_htotal", f), meas_htotal, LINE_TOT);
        if (r.rst_line < 0) begin
            ev = r.n_lines * HDISP;
            eo = r.n_lines;
            if (r.bad_line >= 0 && r.bad_len < HDISP) begin
                ev = ev - (HDISP - r.bad_len);
                eo = eo - 1;
            end
            check($sformatf("f%0d_n_valid", f), n_valid, r.exp_lock ? ev : 0);
            check($sformatf("f%0d_n_sof", f), n_sof, r.exp_lock ? 1 : 0);
            check($sformatf("f%0d_n_eol", f), n_eol, r.exp_lock ? eo : 0);
        end
    endtask

    initial begin
        //             lines bad  len rst lock err vtot
        tbl[0]  = rec(8, -1,  0, -1, 0, 0,  0);  // first VS: enter CHECK
        tbl[1]  = rec(8, -1,  0, -1, 0, 0, 14);
        tbl[2]  = rec(8, -1,  0, -1, 1, 0, 14);  // locked after third VS
        tbl[3]  = rec(8, -1,  0, -1, 1, 0, 14);
        tbl[4]  = rec(8,  3, 17, -1, 1, 1, 14);  // overrun line while locked
        tbl[5]  = rec(8, -1,  0, -1, 0, 1, 14);  // frame verdict drops lock
        tbl[6]  = rec(8, -1,  0, -1, 0, 0, 14);
        tbl[7]  = rec(8, -1,  0, -1, 0, 0, 14);
        tbl[8]  = rec(8, -1,  0, -1, 1, 0, 14);  // relocked
        tbl[9]  = rec(7, -1,  0, -1, 1, 0, 14);  // one line short
        tbl[10] = rec(8, -1,  0, -1, 0, 1, 13);
        tbl[11] = rec(8, -1,  0, -1, 0, 0, 14);
        tbl[12] = rec(8,  2, 10, -1, 0, 1, 14);  // CHECK: good/bad alternation
        tbl[13] = rec(8, -1,  0, -1, 0, 0, 14);
        tbl[14] = rec(8,  5, 10, -1, 0, 1, 14);
        tbl[15] = rec(8, -1,  0, -1, 0, 0, 14);
        tbl[16] = rec(8, -1,  0, -1, 0, 0, 14);
        tbl[17] = rec(8, -1,  0, -1, 1, 0, 14);
        tbl[18] = rec(8, -1,  0,  2, 1, 0,  0);  // reset mid-line while locked
        tbl[19] = rec(8, -1,  0, -1, 0, 0,  0);
        tbl[20] = rec(8, -1,  0, -1, 0, 0, 14);
        tbl[21] = rec(8, -1,  0, -1, 1, 0, 14);

        vid.vid_hs    = 1'b1;
        vid.vid_vs    = 1'b1;
        vid.vid_blank = 1'b0;
        vid.vid_rgb   = 24'h0;
        pixel_rst     = 1'b1;
        repeat (3) @(posedge pixel_clk);
        #1;
        pixel_rst = 1'b0;
        repeat (4) drive_cycle(1'b1, 1'b1, 1'b0, 0, 0);
        check("idle_locked", locked, 64'd0);
        check("idle_meas", {meas_htotal, meas_vtotal}, 64'd0);

        for (int f = 0; f < NF; f++) drive_frame(f, tbl[f]);

        repeat (4) drive_cycle(1'b1, 1'b1, 1'b0, 0, 0);
        check("queue_drained", exp_q.size(), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
